// File: rtl/iomem_arbiter_if.sv
// Signal bundle for iomem_arbiter: two iomem masters, the shared slave bus and the slave responses.
// Modport slave is the arbiter's side; modport master is the side of the surrounding masters and slaves.
interface iomem_arbiter_if;
  logic        m0_valid;
  logic        m0_ready;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic        m1_ready;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_rdata;

  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        gpio_en;
  logic        video_en;
  logic        gpio_ready;
  logic [31:0] gpio_rdata;
  logic        video_ready;
  logic        bus_err;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb, gpio_en, video_en,
    input  gpio_ready, gpio_rdata, video_ready,
    output bus_err
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb, gpio_en, video_en,
    output gpio_ready, gpio_rdata, video_ready,
    input  bus_err
  );
endinterface

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter of two iomem masters onto a shared gpio/video slave bus.
// Optional slave-response timeout enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  iomem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  state_t      state;
  logic        last_grant;  // also the current grant while ISSUE/RESP
  logic        pick;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        slave_ready;
  logic        dec_err;
  logic        timeout_hit;
  logic        done;
  logic [31:0] resp_data;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
    $error("iomem_arbiter: TIMEOUT must be in 2..65535");
  end

  always_comb begin
    pick = 1'b0;
    if (bus.m0_valid && bus.m1_valid) pick = ~last_grant;
    else if (bus.m1_valid)            pick = 1'b1;

    req_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    req_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    req_wstrb = pick ? bus.m1_wstrb : bus.m0_wstrb;

    // Enables are only set in ISSUE, so they double as the registered decode result.
    slave_ready = (bus.gpio_en & bus.gpio_ready) | (bus.video_en & bus.video_ready);
    dec_err     = ~bus.gpio_en & ~bus.video_en;
    done        = slave_ready | dec_err | timeout_hit;

    if (!slave_ready)     resp_data = ERR_DATA;
    else if (bus.gpio_en) resp_data = bus.gpio_rdata;
    else                  resp_data = '0;
  end

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       tcnt <= '0;
    else if (state == ISSUE && !done) tcnt <= tcnt + 16'd1;
    else                             tcnt <= '0;
  end

  assign timeout_hit = (state == ISSUE) && (tcnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      bus.s_valid  <= 1'b0;
      bus.s_addr   <= '0;
      bus.s_wdata  <= '0;
      bus.s_wstrb  <= '0;
      bus.gpio_en  <= 1'b0;
      bus.video_en <= 1'b0;
      bus.m0_ready <= 1'b0;
      bus.m1_ready <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_valid || bus.m1_valid) begin
            last_grant   <= pick;
            bus.s_addr   <= req_addr;
            bus.s_wdata  <= req_wdata;
            bus.s_wstrb  <= req_wstrb;
            bus.s_valid  <= 1'b1;
            bus.gpio_en  <= (req_addr[31:24] == 8'h03);
            bus.video_en <= (req_addr[31:24] == 8'h05);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (done) begin
            bus.s_valid  <= 1'b0;
            bus.gpio_en  <= 1'b0;
            bus.video_en <= 1'b0;
            if (!slave_ready) bus.bus_err <= 1'b1;
            if (last_grant) begin
              bus.m1_ready <= 1'b1;
              bus.m1_rdata <= resp_data;
            end else begin
              bus.m0_ready <= 1'b1;
              bus.m0_rdata <= resp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          bus.m0_ready <= 1'b0;
          bus.m1_ready <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: expected responses are queued on request and
// compared against the responses captured from the DUT.
module tb_iomem_arbiter;
  localparam int unsigned TO         = 8;
  localparam int unsigned WAIT_LIMIT = 50;

  logic clk = 1'b0;
  logic reset;

  iomem_arbiter_if bus ();

  iomem_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned master;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int unsigned master;
    logic [31:0] rdata;
    int unsigned cyc;
    logic        both;
  } obs_t;

  exp_t sb[$];
  obs_t obs[$];
  int unsigned cyc       = 0;
  int unsigned sv_cycles = 0;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.s_valid) sv_cycles <= sv_cycles + 1;
    if (bus.m0_ready || bus.m1_ready)
      obs.push_back('{master: (bus.m1_ready ? 1 : 0),
                      rdata:  (bus.m1_ready ? bus.m1_rdata : bus.m0_rdata),
                      cyc:    cyc + 1,
                      both:   (bus.m0_ready & bus.m1_ready)});
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m(input int unsigned m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
    end else begin
      bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    obs.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({bus.s_valid, bus.gpio_en, bus.video_en, bus.m0_ready, bus.m1_ready, bus.bus_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {bus.s_valid, bus.gpio_en, bus.video_en, bus.m0_ready, bus.m1_ready, bus.bus_err});
    end
    checks++;
    if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== 68'h0) begin
      errors++;
      $display("FAIL reset_sbus: got addr %h wdata %h wstrb %h, expected all 0", bus.s_addr, bus.s_wdata, bus.s_wstrb);
    end
    checks++;
    if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got m0 %h m1 %h, expected 0", bus.m0_rdata, bus.m1_rdata);
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.s_valid !== 1'b0 || obs.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got s_valid %b responses %0d, expected 0 and 0", bus.s_valid, obs.size());
    end
  endtask

  task automatic test_gpio_write();
    int unsigned t0;
    obs_t o;
    exp_t e;
    sb.delete();
    bus.gpio_ready = 1'b1;  // held high in IDLE too: must be ignored there
    bus.gpio_rdata = 32'h1234_5678;
    drive_m(0, 1'b1, 32'h0300_0000, 32'h0000_A5A5, 4'hF);
    sb.push_back('{master: 0, rdata: 32'h1234_5678});
    t0 = cyc;
    for (int i = 0; i < WAIT_LIMIT && !bus.s_valid; i++) step();
    checks++;
    if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h0300_0000 || bus.s_wdata !== 32'h0000_A5A5 ||
        bus.s_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL gpio_issue_bus: got valid %b addr %h wdata %h wstrb %h, expected 1 03000000 0000a5a5 f",
               bus.s_valid, bus.s_addr, bus.s_wdata, bus.s_wstrb);
    end
    checks++;
    if (bus.gpio_en !== 1'b1 || bus.video_en !== 1'b0) begin
      errors++;
      $display("FAIL gpio_issue_sel: got gpio_en %b video_en %b, expected 1 0", bus.gpio_en, bus.video_en);
    end
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(0, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL gpio_resp: got no m0_ready within %0d cycles, expected one", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || o.both !== 1'b0) begin
        errors++;
        $display("FAIL gpio_resp: got master %0d rdata %h both %b, expected master %0d rdata %h both 0",
                 o.master, o.rdata, o.both, e.master, e.rdata);
      end
      checks++;
      // valid cycle counted as the first, ready cycle as the last
      if (o.cyc - t0 + 1 != 3) begin
        errors++;
        $display("FAIL gpio_latency: got %0d cycles, expected 3", o.cyc - t0 + 1);
      end
    end
    step();
    step();
    checks++;
    if (obs.size() != 0 || bus.s_valid !== 1'b0) begin
      errors++;
      $display("FAIL gpio_single_pulse: got %0d extra responses s_valid %b, expected 0 0", obs.size(), bus.s_valid);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    exp_t e;
    pulse_reset();
    bus.gpio_ready = 1'b1;
    bus.gpio_rdata = 32'hCAFE_0000;
    drive_m(0, 1'b1, 32'h0300_0010, '0, 4'h0);
    drive_m(1, 1'b1, 32'h0300_0020, '0, 4'h0);
    for (int k = 0; k < 4; k++) sb.push_back('{master: k % 2, rdata: 32'hCAFE_0000 + k});
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
      bus.gpio_rdata = 32'hCAFE_0000 + k + 1;
      if (k == 3) begin
        drive_m(0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, '0, '0, '0);
      end
      checks++;
      if (obs.size() == 0) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got no ready within %0d cycles, expected master %0d", k, WAIT_LIMIT, k % 2);
        drive_m(0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, '0, '0, '0);
        break;
      end
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || o.both !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got master %0d rdata %h both %b, expected master %0d rdata %h both 0",
                 k, o.master, o.rdata, o.both, e.master, e.rdata);
      end
    end
    step();
    step();
    step();
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL rr_extra: got %0d extra responses, expected 0", obs.size());
    end
  endtask

  task automatic test_decode_error();
    int unsigned sv0;
    obs_t o;
    exp_t e;
    sb.delete();
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL dec_err_before: got bus_err %b, expected 0", bus.bus_err);
    end
    sv0 = sv_cycles;
    drive_m(1, 1'b1, 32'h0700_0000, '0, 4'h0);
    sb.push_back('{master: 1, rdata: 32'hDEAD_BEEF});
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(1, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL dec_err_resp: got no m1_ready within %0d cycles, expected one", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL dec_err_resp: got master %0d rdata %h, expected master %0d rdata %h",
                 o.master, o.rdata, e.master, e.rdata);
      end
    end
    checks++;
    if (sv_cycles - sv0 != 1) begin
      errors++;
      $display("FAIL dec_err_svalid: got %0d s_valid cycles, expected 1", sv_cycles - sv0);
    end
    checks++;
    if (bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL dec_err_flag: got bus_err %b, expected 1", bus.bus_err);
    end
    step();
    bus.gpio_ready = 1'b1;
    bus.gpio_rdata = 32'h1111_2222;
    drive_m(0, 1'b1, 32'h0300_0004, '0, 4'h0);
    sb.push_back('{master: 0, rdata: 32'h1111_2222});
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(0, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL sticky_resp: got no m0_ready within %0d cycles, expected one", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || bus.bus_err !== 1'b1) begin
        errors++;
        $display("FAIL sticky_resp: got master %0d rdata %h bus_err %b, expected master %0d rdata %h bus_err 1",
                 o.master, o.rdata, bus.bus_err, e.master, e.rdata);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    obs_t o;
    exp_t e;
    sb.delete();
    bus.gpio_ready = 1'b0;
    drive_m(0, 1'b1, 32'h0300_0008, 32'h5555_AAAA, 4'h3);
    for (int i = 0; i < WAIT_LIMIT && !bus.s_valid; i++) step();
    checks++;
    if (bus.s_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: got s_valid %b, expected 1", bus.s_valid);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    drive_m(0, 1'b0, '0, '0, '0);
    checks++;
    if ({bus.s_valid, bus.gpio_en, bus.video_en, bus.m0_ready, bus.m1_ready, bus.bus_err} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_flags: got %b, expected 000000",
               {bus.s_valid, bus.gpio_en, bus.video_en, bus.m0_ready, bus.m1_ready, bus.bus_err});
    end
    checks++;
    if ({bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_rdata, bus.m1_rdata} !== 132'h0) begin
      errors++;
      $display("FAIL midrst_data: got addr %h wdata %h wstrb %h m0 %h m1 %h, expected all 0",
               bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m0_rdata, bus.m1_rdata);
    end
    step();
    reset = 1'b0;
    bus.gpio_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL midrst_no_ready: got %0d responses, expected 0", obs.size());
    end
    obs.delete();
    bus.gpio_rdata = 32'h7777_0000;
    drive_m(0, 1'b1, 32'h0300_0030, '0, 4'h0);
    drive_m(1, 1'b1, 32'h0300_0040, '0, 4'h0);
    sb.push_back('{master: 0, rdata: 32'h7777_0000});
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(0, 1'b0, '0, '0, '0);
    drive_m(1, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL midrst_tie: got no ready within %0d cycles, expected master 0", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || o.both !== 1'b0) begin
        errors++;
        $display("FAIL midrst_tie: got master %0d rdata %h both %b, expected master %0d rdata %h both 0",
                 o.master, o.rdata, o.both, e.master, e.rdata);
      end
    end
    step();
    step();
  endtask

  task automatic test_video();
    obs_t o;
    exp_t e;
    sb.delete();
    bus.gpio_ready  = 1'b0;
    bus.gpio_rdata  = 32'hFFFF_FFFF;
    bus.video_ready = 1'b1;
    drive_m(0, 1'b1, 32'h0500_0010, 32'h0000_0042, 4'h1);
    sb.push_back('{master: 0, rdata: 32'h0000_0000});
    step();
    checks++;
    if (bus.s_valid !== 1'b1 || bus.video_en !== 1'b1 || bus.gpio_en !== 1'b0) begin
      errors++;
      $display("FAIL video_sel: got s_valid %b video_en %b gpio_en %b, expected 1 1 0",
               bus.s_valid, bus.video_en, bus.gpio_en);
    end
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(0, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL video_resp: got no m0_ready within %0d cycles, expected one", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || bus.bus_err !== 1'b0) begin
        errors++;
        $display("FAIL video_resp: got master %0d rdata %h bus_err %b, expected master %0d rdata %h bus_err 0",
                 o.master, o.rdata, bus.bus_err, e.master, e.rdata);
      end
    end
    step();
  endtask

  task automatic test_timeout();
    int unsigned t0;
    int unsigned sv0;
`ifdef IOMEM_ARB_TIMEOUT_EN
    obs_t o;
    exp_t e;
`endif
    pulse_reset();
    bus.video_ready = 1'b0;
    bus.gpio_ready  = 1'b1;
    t0  = cyc;
    sv0 = sv_cycles;
    drive_m(0, 1'b1, 32'h0500_0000, 32'h0000_00FF, 4'h1);
`ifdef IOMEM_ARB_TIMEOUT_EN
    sb.push_back('{master: 0, rdata: 32'hDEAD_BEEF});
    for (int i = 0; i < WAIT_LIMIT && obs.size() == 0; i++) step();
    drive_m(0, 1'b0, '0, '0, '0);
    checks++;
    if (obs.size() == 0) begin
      errors++;
      $display("FAIL timeout_resp: got no m0_ready within %0d cycles, expected one", WAIT_LIMIT);
    end else begin
      o = obs.pop_front();
      e = sb.pop_front();
      if (o.master != e.master || o.rdata !== e.rdata || bus.bus_err !== 1'b1) begin
        errors++;
        $display("FAIL timeout_resp: got master %0d rdata %h bus_err %b, expected master %0d rdata %h bus_err 1",
                 o.master, o.rdata, bus.bus_err, e.master, e.rdata);
      end
      checks++;
      if (sv_cycles - sv0 != TO || o.cyc - t0 + 1 != TO + 2) begin
        errors++;
        $display("FAIL timeout_len: got %0d ISSUE cycles latency %0d, expected %0d and %0d",
                 sv_cycles - sv0, o.cyc - t0 + 1, TO, TO + 2);
      end
    end
    step();
`else
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (obs.size() != 0 || bus.s_valid !== 1'b1 || bus.bus_err !== 1'b0 || sv_cycles - sv0 != 40) begin
      errors++;
      $display("FAIL no_timeout_wait: got responses %0d s_valid %b bus_err %b issue cycles %0d, expected 0 1 0 40",
               obs.size(), bus.s_valid, bus.bus_err, sv_cycles - sv0);
    end
    drive_m(0, 1'b0, '0, '0, '0);
    pulse_reset();
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive_m(0, 1'b0, '0, '0, '0);
    drive_m(1, 1'b0, '0, '0, '0);
    bus.gpio_ready  = 1'b0;
    bus.gpio_rdata  = '0;
    bus.video_ready = 1'b0;

    test_reset();
    test_gpio_write();
    test_round_robin();
    test_decode_error();
    test_reset_mid_issue();
    test_video();
    test_timeout();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
